// File: rtl/ff_readback_ser.sv
// ff_readback_ser
// Serial readback engine for register banks. A capture request snapshots a
// WIDTH-bit parallel word, which is then shifted out LSB-first followed by an
// even-parity bit (XOR of all captured bits).
//
// Handshake: a beat is transferred on a rising edge of C where SV=1 and SR=1.
// While SV=1 and SR=0, SO and SV hold their values. SR has no effect while SV=0.
//
// Ports:
//   C         clock, rising edge
//   RN        asynchronous active-low reset
//   CAP       capture request (ignored while a frame is in progress)
//   D         parallel state word, sampled only on the capture edge
//   SR        serial ready from downstream
//   SO        serial data bit
//   SV        serial valid
//   BUSY      frame in progress
//   DONE      one-cycle pulse after the parity beat is accepted
//   dbg_state current FSM state (IDLE=0, DATA=1, PAR=2) for observation
module ff_readback_ser #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             C,
    input  logic             RN,
    input  logic             CAP,
    input  logic [WIDTH-1:0] D,
    input  logic             SR,
    output logic             SO,
    output logic             SV,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q,   par_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             done_q,  done_d;

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (CAP) begin
                    shift_d = D;
                    par_d   = ^D;
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (SR) begin
                    shift_d = shift_q >> 1;
                    // Hold the counter on the last data beat so it never
                    // goes past WIDTH-1.
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_PAR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (SR) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state so an asynchronous reset
    // drops them immediately.
    always_comb begin
        SO = 1'b0;
        SV = 1'b0;
        unique case (state_q)
            ST_DATA: begin
                SV = 1'b1;
                SO = shift_q[0];
            end
            ST_PAR: begin
                SV = 1'b1;
                SO = par_q;
            end
            default: begin
                SV = 1'b0;
                SO = 1'b0;
            end
        endcase
    end

    assign BUSY      = SV;
    assign DONE      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ff_readback_ser.sv
module tb_ff_readback_ser;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         c = 1'b0;
    logic         rn;
    logic         cap;
    logic [W-1:0] d;
    logic         sr;
    logic         so, sv, busy, done;
    logic [1:0]   dbg_state;

    logic         cap2;
    logic [1:0]   d2;
    logic         sr2;
    logic         so2, sv2, busy2, done2;
    logic [1:0]   dbg_state2;

    always #5 c = ~c;

    ff_readback_ser #(.WIDTH(W)) dut (
        .C(c), .RN(rn), .CAP(cap), .D(d), .SR(sr),
        .SO(so), .SV(sv), .BUSY(busy), .DONE(done), .dbg_state(dbg_state)
    );

    ff_readback_ser #(.WIDTH(2)) dut2 (
        .C(c), .RN(rn), .CAP(cap2), .D(d2), .SR(sr2),
        .SO(so2), .SV(sv2), .BUSY(busy2), .DONE(done2), .dbg_state(dbg_state2)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Frame-level model: a capture while idle queues the WIDTH data bits and
    // the parity bit; each accepted beat pops one; draining the queue ends the
    // frame and schedules a DONE cycle.
    logic [0:0] exp_q[$];
    logic       m_busy   = 1'b0;
    logic       m_done   = 1'b0;
    logic       check_en = 1'b0;
    logic       hold_pend = 1'b0;
    logic       hold_so   = 1'b0;
    int         sv_cnt   = 0;
    int         done_cnt = 0;

    always @(negedge c) begin
        if (check_en) begin
            logic b;
            b = m_busy;
            chk("sv", sv, b);
            chk("busy", busy, b);
            chk("done", done, m_done);
            if (!b) chk("so_idle", so, 0);
            if (hold_pend) begin
                chk("hold_so", so, hold_so);
                chk("hold_sv", sv, 1);
            end
            if (sv) sv_cnt++;
            if (done) done_cnt++;
            m_done = 1'b0;
            hold_pend = b && !sr;
            hold_so   = so;
            if (b && sr) begin
                if (exp_q.size() == 0) begin
                    chk("underflow", 1, 0);
                end else begin
                    chk("so_beat", so, exp_q[0]);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
            if (!b && cap) begin
                for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
                exp_q.push_back(^d);
                m_busy = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic capture(input logic [W-1:0] val);
        d   = val;
        cap = 1'b1;
        tick();
        cap = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((m_busy || exp_q.size() != 0) && k < 400) begin
            tick();
            k++;
        end
        chk("idle_bound", (k < 400), 1);
        tick();
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rn = 1'b0; cap = 1'b0; d = '0; sr = 1'b0;
        cap2 = 1'b0; d2 = '0; sr2 = 1'b0;
        tick();
        tick();
        chk("rst_so", so, 0);
        chk("rst_sv", sv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rn = 1'b1;
        check_en = 1'b1;
        tick();

        // A5 with SR held high: 9 valid cycles, one DONE.
        sr = 1'b1;
        sv_cnt = 0; done_cnt = 0;
        capture(8'hA5);
        wait_idle();
        chk("a5_sv_cycles", sv_cnt, 9);
        chk("a5_done_cnt", done_cnt, 1);

        // 07 with SR toggling 1,0,1,0...: 17 cycles from first SV to last accept.
        sv_cnt = 0;
        capture(8'h07);
        sr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            sr = ~sr;
        end
        sr = 1'b1;
        wait_idle();
        chk("07_sv_cycles", sv_cnt, 17);

        // 3C with CAP re-asserted and D=FF mid-frame: ignored, one DONE.
        done_cnt = 0;
        capture(8'h3C);
        tick(); tick(); tick();
        d = 8'hFF; cap = 1'b1;
        tick(); tick();
        cap = 1'b0; d = '0;
        wait_idle();
        chk("3c_done_cnt", done_cnt, 1);

        // CAP held high with D=01: frames repeat with a one-cycle bubble.
        done_cnt = 0;
        d = 8'h01; cap = 1'b1;
        repeat (25) tick();
        cap = 1'b0;
        wait_idle();
        chk("held_done_cnt", done_cnt, 3);

        // Reset pulse during beat 4.
        capture($urandom_range(0, 255));
        tick(); tick(); tick();
        #2;
        rn = 1'b0;
        check_en = 1'b0;
        #1;
        chk("arst_sv", sv, 0);
        chk("arst_busy", busy, 0);
        chk("arst_so", so, 0);
        chk("arst_done", done, 0);
        exp_q.delete();
        m_busy = 1'b0; m_done = 1'b0; hold_pend = 1'b0;
        tick();
        rn = 1'b1;
        check_en = 1'b1;
        done_cnt = 0;
        repeat (4) tick();
        chk("arst_no_done", done_cnt, 0);
        capture(8'h5A);
        wait_idle();
        chk("post_rst_done", done_cnt, 1);

        // Randomized CAP / D / SR.
        for (int i = 0; i < 400; i++) begin
            cap = ($urandom_range(0, 7) == 0);
            d   = W'($urandom);
            sr  = ($urandom_range(0, 9) < 7);
            tick();
        end
        cap = 1'b0; sr = 1'b1;
        wait_idle();
        chk("rand_drained", exp_q.size(), 0);

        // WIDTH=2, D=2'b10: SO 0,1 then parity 1; DONE three cycles after first SV.
        d2 = 2'b10; sr2 = 1'b1; cap2 = 1'b1;
        tick();
        cap2 = 1'b0; d2 = 2'b00;
        @(negedge c);
        chk("w2_sv0", sv2, 1);
        chk("w2_so0", so2, 0);
        @(negedge c);
        chk("w2_sv1", sv2, 1);
        chk("w2_so1", so2, 1);
        @(negedge c);
        chk("w2_svp", sv2, 1);
        chk("w2_par", so2, 1);
        @(negedge c);
        chk("w2_done", done2, 1);
        chk("w2_done_sv", sv2, 0);
        chk("w2_done_busy", busy2, 0);
        @(negedge c);
        chk("w2_done_pulse", done2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
